// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and the controller state.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        ALU_SLL   = 4'b0000,
        ALU_SRL   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0011,
        ALU_AND   = 4'b0100,
        ALU_OR    = 4'b0101,
        ALU_XOR   = 4'b0110,
        ALU_NOR   = 4'b0111,
        ALU_SLT   = 4'b1010,
        ALU_SLTU  = 4'b1011,
        ALU_MULLO = 4'b1100,
        ALU_MULHI = 4'b1101
    } aluop_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Radix-2 shift-add unsigned multiplier; one partial-product step per cycle, WIDTH steps.
module alu_mc_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      count;
    logic               busy;
    logic [WIDTH:0]     upper;

    // prod is the value after the current step, so the last step can be captured directly.
    assign upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    assign prod  = {upper, p[WIDTH-1:1]};
    assign done  = busy && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            p     <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            p     <= prod;
            count <= count + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready request and result ports.
// Define ALU_MUL_EN to build the iterative MULLO/MULHI ops.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output alu_state_t       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // requester holds its request while ready is low, and result/flags stay stable
    // while out_valid && !out_ready.
    logic             accept;
    logic [WIDTH-1:0] sum, diff, d_result;
    logic             d_ovf, d_illegal;

    assign sum    = portA + portB;
    assign diff   = portA - portB;
    assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
    alu_state_t         state;
    logic               is_mul, mul_hi, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_half;

    alu_mc_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (CLK),
        .rst   (RST),
        .start (accept && is_mul),
        .a     (portA),
        .b     (portB),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign mul_half  = mul_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign dbg_state = state;
`else
    assign in_ready  = !out_valid || out_ready;
    assign dbg_state = IDLE;
`endif

    always_comb begin
        d_result  = '0;
        d_ovf     = 1'b0;
        d_illegal = 1'b0;
`ifdef ALU_MUL_EN
        is_mul    = 1'b0;
`endif
        case (aluop)
            ALU_SLL:  d_result = portA << portB[SHAMT_W-1:0];
            ALU_SRL:  d_result = portA >> portB[SHAMT_W-1:0];
            ALU_ADD: begin
                d_result = sum;
                d_ovf    = (portA[WIDTH-1] == portB[WIDTH-1]) && (sum[WIDTH-1] != portA[WIDTH-1]);
            end
            ALU_SUB: begin
                d_result = diff;
                d_ovf    = (portA[WIDTH-1] != portB[WIDTH-1]) && (diff[WIDTH-1] != portA[WIDTH-1]);
            end
            ALU_AND:  d_result = portA & portB;
            ALU_OR:   d_result = portA | portB;
            ALU_XOR:  d_result = portA ^ portB;
            ALU_NOR:  d_result = ~(portA | portB);
            ALU_SLT:  d_result = WIDTH'($signed(portA) < $signed(portB));
            ALU_SLTU: d_result = WIDTH'(portA < portB);
`ifdef ALU_MUL_EN
            ALU_MULLO, ALU_MULHI: is_mul = 1'b1;
`endif
            default:  d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            state     <= IDLE;
            mul_hi    <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
`ifdef ALU_MUL_EN
                if (is_mul) begin
                    state  <= MUL;
                    mul_hi <= aluop[0];
                end else
`endif
                begin
                    out_valid <= 1'b1;
                    result    <= d_result;
                    neg       <= d_result[WIDTH-1];
                    zero      <= (d_result == '0);
                    ovf       <= d_ovf;
                    illegal   <= d_illegal;
                end
            end
`ifdef ALU_MUL_EN
            // The multiplier's final step lands in the output register on the same edge.
            if ((state == MUL) && mul_done) begin
                state     <= IDLE;
                out_valid <= 1'b1;
                result    <= mul_half;
                neg       <= mul_half[WIDTH-1];
                zero      <= (mul_half == '0);
                ovf       <= 1'b0;
                illegal   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed scenarios plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    logic in_valid, in_ready, out_valid, out_ready;
    logic neg, zero, ovf, illegal;
    logic [W-1:0] portA, portB, result;
    logic [3:0] aluop;
    alu_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    always #5 CLK = ~CLK;

    alu_mc #(.WIDTH(W), .SHAMT_W(5)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .portA(portA), .portB(portB), .aluop(aluop), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .neg(neg), .zero(zero),
        .ovf(ovf), .illegal(illegal), .dbg_state(dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        aluop    = op;
        portA    = a;
        portB    = b;
    endtask

    task automatic set_ready(input logic r);
        out_ready = r;
        #1;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model: {illegal, ovf, result} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, s, smax, smin;
        logic [2*W-1:0] p;
        logic [W-1:0] r;
        logic o, il;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        r = '0; o = 1'b0; il = 1'b0; p = '0;
        case (op)
            4'd0:  r = a << (b % W);
            4'd1:  r = a >> (b % W);
            4'd2:  begin s = sa + sb; r = s[W-1:0]; o = (s > smax) || (s < smin); end
            4'd3:  begin s = sa - sb; r = s[W-1:0]; o = (s > smax) || (s < smin); end
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd10: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd11: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'd12: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
            4'd13: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
`endif
            default: il = 1'b1;
        endcase
        return {il, o, r};
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aluop = '0; portA = '0; portB = '0;
        repeat (2) @(negedge CLK);
        checks++; if ({out_valid, neg, zero, ovf, illegal} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {out_valid, neg, zero, ovf, illegal}); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        RST = 1'b0;
        tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_add_ovf;
        set_ready(1'b1);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        tick;
        in_valid = 1'b0;
        checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got %h exp 80000000", result); end
        checks++; if ({out_valid, ovf, neg, zero} !== 4'b1110) begin errors++; $display("FAIL add_ovf_flags got %b exp 1110", {out_valid, ovf, neg, zero}); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [3:0]   ops[3] = '{ALU_SUB, ALU_SLT, ALU_SLTU};
        logic [W-1:0] as[3]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] bs[3]  = '{32'd5, 32'd1, 32'd1};
        logic [W-1:0] rs[3]  = '{32'd0, 32'd1, 32'd0};
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i]);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
            tick;
            checks++; if ({out_valid, result} !== {1'b1, rs[i]}) begin errors++; $display("FAIL b2b_result[%0d] got %b/%h exp 1/%h", i, out_valid, result, rs[i]); end
            checks++; if (zero !== (rs[i] == '0)) begin errors++; $display("FAIL b2b_zero[%0d] got %b exp %b", i, zero, rs[i] == '0); end
        end
        in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_hold;
        set_ready(1'b0);
        drive(ALU_SLL, 32'h1, 32'h21);
        tick;
        // Next request is presented and held while the output is stalled.
        drive(ALU_ADD, 32'd2, 32'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({out_valid, result} !== {1'b1, 32'h2}) begin errors++; $display("FAIL hold_result[%0d] got %b/%h exp 1/00000002", i, out_valid, result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
            if (i < 2) tick;
        end
        set_ready(1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_consume_ready got %b exp 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++; if ({out_valid, result} !== {1'b1, 32'd5}) begin errors++; $display("FAIL hold_next got %b/%h exp 1/00000005", out_valid, result); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_single_accept got %b exp 0", out_valid); end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul;
        logic [3:0]   ops[2] = '{ALU_MULHI, ALU_MULLO};
        logic [W-1:0] rs[2]  = '{32'hFFFF_FFFE, 32'h0000_0001};
        int cyc, busy;
        set_ready(1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(ops[k], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            tick;
            in_valid = 1'b0;
            checks++; if (dbg_state !== MUL) begin errors++; $display("FAIL mul_state[%0d] got %0d exp %0d", k, dbg_state, MUL); end
            cyc = 1; busy = 0;
            while (!out_valid && cyc < 100) begin
                if (!in_ready) busy++;
                tick;
                cyc++;
            end
            checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp 33", k, cyc); end
            checks++; if (busy !== 32) begin errors++; $display("FAIL mul_busy[%0d] got %0d exp 32", k, busy); end
            checks++; if (result !== rs[k]) begin errors++; $display("FAIL mul_result[%0d] got %h exp %h", k, result, rs[k]); end
        end
        tick;
    endtask
`endif

    task automatic test_reset_mid_op;
        int late;
        set_ready(1'b0);
`ifdef ALU_MUL_EN
        set_ready(1'b1);
        drive(ALU_MULLO, $urandom, $urandom);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
`else
        drive(ALU_ADD, 32'd7, 32'd8);
        tick;
        in_valid = 1'b0;
`endif
        RST = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid valid/ready got %b exp 01", {out_valid, in_ready}); end
        checks++; if ({result, dbg_state} !== {{W{1'b0}}, IDLE}) begin errors++; $display("FAIL rst_mid result/state got %h/%0d exp 0/0", result, dbg_state); end
        @(negedge CLK);
        RST = 1'b0;
        set_ready(1'b1);
        drive(ALU_ADD, 32'd2, 32'd3);
        tick;
        in_valid = 1'b0;
        checks++; if ({out_valid, result} !== {1'b1, 32'd5}) begin errors++; $display("FAIL rst_add got %b/%h exp 1/00000005", out_valid, result); end
        late = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_valid) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL rst_no_late_result got %0d exp 0", late); end
    endtask

    task automatic test_illegal;
        logic [3:0] ill[$];
        ill = '{4'b1000, 4'b1001, 4'b1110, 4'b1111};
`ifndef ALU_MUL_EN
        ill.push_back(4'b1100);
        ill.push_back(4'b1101);
`endif
        set_ready(1'b1);
        foreach (ill[i]) begin
            drive(ill[i], 32'hFFFF_FFFF, $urandom);
            tick;
            in_valid = 1'b0;
            checks++; if ({out_valid, illegal, zero, ovf, neg} !== 5'b11100) begin errors++; $display("FAIL illegal_flags op %b got %b exp 11100", ill[i], {out_valid, illegal, zero, ovf, neg}); end
            checks++; if (result !== '0) begin errors++; $display("FAIL illegal_result op %b got %h exp 0", ill[i], result); end
        end
        tick;
    endtask

    task automatic test_random;
        logic [W+1:0] e;
        logic acc, con;
        int budget;
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0)
                drive(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
            #1;
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rand_unexpected got %h exp none", result); end
                else begin
                    e = exp_q.pop_front();
                    if ({illegal, ovf, result} !== e) begin errors++; $display("FAIL rand_result got %b/%b/%h exp %b/%b/%h", illegal, ovf, result, e[W+1], e[W], e[W-1:0]); end
                    checks++; if ({neg, zero} !== {e[W-1], e[W-1:0] == '0}) begin errors++; $display("FAIL rand_nz got %b exp %b", {neg, zero}, {e[W-1], e[W-1:0] == '0}); end
                end
            end
            if (acc) exp_q.push_back(model(aluop, portA, portB));
            tick;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        set_ready(1'b1);
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++; if ({illegal, ovf, result} !== e) begin errors++; $display("FAIL rand_drain got %b/%b/%h exp %b/%b/%h", illegal, ovf, result, e[W+1], e[W], e[W-1:0]); end
            end
            tick;
            budget++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing got %0d left exp 0", exp_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_extra got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_add_ovf;
        test_back_to_back;
        test_hold;
`ifdef ALU_MUL_EN
        test_mul;
`endif
        test_reset_mid_op;
        test_illegal;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
